io_stage: RTL and testbench

- Memory/IO pipeline stage directly downstream of the execute stage.
- Latches the execute-to-IO bus and selects the final writeback value from: ALU result, load data from the synchronous data SRAM, or the HI/LO registers.
- Owns the architectural HI/LO registers. Stalls until a pending divide completes.
- Drives the writeback bus and a back-pass bus to decode for hazard detection.

---
 rtl/io_stage.sv | 148 ++++++++++++++
 tb/tb_io_stage.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_stage.sv
// Memory/IO pipeline stage: latches the execute bus, picks the writeback value
// (ALU, load data or HI/LO), owns HI/LO and stalls for an outstanding divide.
module io_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wb_allow_in,
  output logic                      io_allow_in,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     ex_program_count,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [REG_ADDR_WIDTH-1:0] ex_destination_register,
  input  logic                      ex_register_write,
  input  logic                      ex_result_is_from_memory,
  input  logic                      ex_multiply_valid,
  input  logic                      ex_divide_valid,
  input  logic                      ex_result_high,
  input  logic                      ex_result_low,
  input  logic                      ex_high_low_write,
  input  logic [2*DATA_WIDTH-1:0]   multiply_result,
  input  logic                      divide_result_valid,
  input  logic [DATA_WIDTH-1:0]     divide_result,
  input  logic [DATA_WIDTH-1:0]     divide_remain,
  input  logic [DATA_WIDTH-1:0]     data_read_data,
  output logic                      io_to_wb_valid,
  output logic [DATA_WIDTH-1:0]     io_to_wb_program_count,
  output logic [DATA_WIDTH-1:0]     io_to_wb_result,
  output logic [REG_ADDR_WIDTH-1:0] io_to_wb_destination_register,
  output logic                      io_to_wb_register_write,
  output logic                      io_back_pass_valid,
  output logic [REG_ADDR_WIDTH-1:0] io_back_pass_register
);

  logic                      r_ioValid;
  logic                      r_firstCycle;
  logic                      r_loadHoldValid;
  logic [DATA_WIDTH-1:0]     r_loadHold;
  logic [2*DATA_WIDTH-1:0]   r_mulHold;
  logic [DATA_WIDTH-1:0]     r_hi;
  logic [DATA_WIDTH-1:0]     r_lo;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [DATA_WIDTH-1:0]     r_alu;
  logic [REG_ADDR_WIDTH-1:0] r_dest;
  logic                      r_regWrite;
  logic                      r_fromMem;
  logic                      r_mulValid;
  logic                      r_divValid;
  logic                      r_resHigh;
  logic                      r_resLow;
  logic                      r_hlWrite;

  logic                      w_readyGo;
  logic                      w_ioAllowIn;
  logic                      w_fire;
  logic [DATA_WIDTH-1:0]     w_loadData;
  logic [2*DATA_WIDTH-1:0]   w_mulData;
  logic [DATA_WIDTH-1:0]     w_result;

  assign w_readyGo   = !(r_ioValid && r_divValid) || divide_result_valid;
  assign w_ioAllowIn = !r_ioValid || (w_readyGo && wb_allow_in);
  assign w_fire      = r_ioValid && w_readyGo && wb_allow_in;

  // SRAM data and the multiplier output are only live in the first IO cycle
  assign w_loadData = r_loadHoldValid ? r_loadHold : data_read_data;
  assign w_mulData  = r_firstCycle ? multiply_result : r_mulHold;

  always_comb begin
    w_result = r_alu;
    if (r_fromMem)                   w_result = w_loadData;
    else if (r_resHigh && !r_hlWrite) w_result = r_hi;
    else if (r_resLow && !r_hlWrite)  w_result = r_lo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ioValid       <= 1'b0;
      r_firstCycle    <= 1'b0;
      r_loadHoldValid <= 1'b0;
      r_loadHold      <= '0;
      r_mulHold       <= '0;
      r_pc            <= '0;
      r_alu           <= '0;
      r_dest          <= '0;
      r_regWrite      <= 1'b0;
      r_fromMem       <= 1'b0;
      r_mulValid      <= 1'b0;
      r_divValid      <= 1'b0;
      r_resHigh       <= 1'b0;
      r_resLow        <= 1'b0;
      r_hlWrite       <= 1'b0;
    end else begin
      if (w_ioAllowIn) r_ioValid <= ex_valid;
      if (ex_valid && w_ioAllowIn) begin
        r_pc            <= ex_program_count;
        r_alu           <= ex_alu_result;
        r_dest          <= ex_destination_register;
        r_regWrite      <= ex_register_write;
        r_fromMem       <= ex_result_is_from_memory;
        r_mulValid      <= ex_multiply_valid;
        r_divValid      <= ex_divide_valid;
        r_resHigh       <= ex_result_high;
        r_resLow        <= ex_result_low;
        r_hlWrite       <= ex_high_low_write;
        r_firstCycle    <= 1'b1;
        r_loadHoldValid <= 1'b0;
      end else begin
        r_firstCycle <= 1'b0;
        if (r_firstCycle && r_fromMem) begin
          r_loadHold      <= data_read_data;
          r_loadHoldValid <= 1'b1;
        end
        if (r_firstCycle && r_mulValid) r_mulHold <= multiply_result;
      end
    end
  end

  // HI/LO commit at fire so a following mfhi/mflo sees the new value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fire) begin
      if (r_mulValid) begin
        r_hi <= w_mulData[2*DATA_WIDTH-1:DATA_WIDTH];
        r_lo <= w_mulData[DATA_WIDTH-1:0];
      end else if (r_divValid) begin
        r_lo <= divide_result;
        r_hi <= divide_remain;
      end else if (r_hlWrite && r_resHigh) begin
        r_hi <= r_alu;
      end else if (r_hlWrite && r_resLow) begin
        r_lo <= r_alu;
      end
    end
  end

  assign io_allow_in                   = w_ioAllowIn;
  assign io_to_wb_valid                = r_ioValid && w_readyGo;
  assign io_to_wb_program_count        = r_pc;
  assign io_to_wb_result               = w_result;
  assign io_to_wb_destination_register = r_dest;
  assign io_to_wb_register_write       = r_regWrite;
  assign io_back_pass_valid            = r_ioValid && r_regWrite;
  assign io_back_pass_register         = r_dest;

endmodule

// File: tb/tb_io_stage.sv
// Self-checking bench for io_stage: directed scenarios plus a randomized
// instruction stream compared against a HI/LO reference model.
module tb_io_stage;

  localparam int K_ALU  = 0;
  localparam int K_LOAD = 1;
  localparam int K_MULT = 2;
  localparam int K_DIV  = 3;
  localparam int K_MFHI = 4;
  localparam int K_MFLO = 5;
  localparam int K_MTHI = 6;
  localparam int K_MTLO = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_allow_in;
  logic        io_allow_in;
  logic        ex_valid;
  logic [31:0] ex_program_count;
  logic [31:0] ex_alu_result;
  logic [4:0]  ex_destination_register;
  logic        ex_register_write;
  logic        ex_result_is_from_memory;
  logic        ex_multiply_valid;
  logic        ex_divide_valid;
  logic        ex_result_high;
  logic        ex_result_low;
  logic        ex_high_low_write;
  logic [63:0] multiply_result;
  logic        divide_result_valid;
  logic [31:0] divide_result;
  logic [31:0] divide_remain;
  logic [31:0] data_read_data;
  logic        io_to_wb_valid;
  logic [31:0] io_to_wb_program_count;
  logic [31:0] io_to_wb_result;
  logic [4:0]  io_to_wb_destination_register;
  logic        io_to_wb_register_write;
  logic        io_back_pass_valid;
  logic [4:0]  io_back_pass_register;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  io_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .wb_allow_in(wb_allow_in), .io_allow_in(io_allow_in),
    .ex_valid(ex_valid), .ex_program_count(ex_program_count), .ex_alu_result(ex_alu_result),
    .ex_destination_register(ex_destination_register), .ex_register_write(ex_register_write),
    .ex_result_is_from_memory(ex_result_is_from_memory), .ex_multiply_valid(ex_multiply_valid),
    .ex_divide_valid(ex_divide_valid), .ex_result_high(ex_result_high), .ex_result_low(ex_result_low),
    .ex_high_low_write(ex_high_low_write), .multiply_result(multiply_result),
    .divide_result_valid(divide_result_valid), .divide_result(divide_result),
    .divide_remain(divide_remain), .data_read_data(data_read_data),
    .io_to_wb_valid(io_to_wb_valid), .io_to_wb_program_count(io_to_wb_program_count),
    .io_to_wb_result(io_to_wb_result), .io_to_wb_destination_register(io_to_wb_destination_register),
    .io_to_wb_register_write(io_to_wb_register_write), .io_back_pass_valid(io_back_pass_valid),
    .io_back_pass_register(io_back_pass_register)
  );

  always #5 clock = ~clock;

  task automatic clearEx();
    ex_valid = 0; ex_program_count = '0; ex_alu_result = '0; ex_destination_register = '0;
    ex_register_write = 0; ex_result_is_from_memory = 0; ex_multiply_valid = 0;
    ex_divide_valid = 0; ex_result_high = 0; ex_result_low = 0; ex_high_low_write = 0;
  endtask

  task automatic driveEx(input int kind, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [4:0] dest, input logic rw);
    ex_valid = 1; ex_program_count = pc; ex_alu_result = alu;
    ex_destination_register = dest; ex_register_write = rw;
    ex_result_is_from_memory = (kind == K_LOAD);
    ex_multiply_valid = (kind == K_MULT);
    ex_divide_valid = (kind == K_DIV);
    ex_result_high = (kind == K_MFHI) || (kind == K_MTHI);
    ex_result_low = (kind == K_MFLO) || (kind == K_MTLO);
    ex_high_low_write = (kind == K_MTHI) || (kind == K_MTLO);
  endtask

  // Architectural meaning of each instruction kind, independent of the stage's structure
  function automatic logic [31:0] modelResult(input int kind, input logic [31:0] alu,
                                              input logic [31:0] ld);
    case (kind)
      K_LOAD:  return ld;
      K_MFHI:  return mHi;
      K_MFLO:  return mLo;
      default: return alu;
    endcase
  endfunction

  task automatic modelRetire(input int kind, input logic [31:0] alu, input logic [63:0] mul,
                             input logic [31:0] q, input logic [31:0] r);
    case (kind)
      K_MULT: begin mHi = mul[63:32]; mLo = mul[31:0]; end
      K_DIV:  begin mHi = r; mLo = q; end
      K_MTHI: mHi = alu;
      K_MTLO: mLo = alu;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (io_to_wb_valid !== 1'b0 || io_back_pass_valid !== 1'b0 || io_allow_in !== 1'b1)
      $display("[TB] FAIL reset_state: got valid=%b bp=%b allow=%b want 0 0 1",
               io_to_wb_valid, io_back_pass_valid, io_allow_in);
    if (io_to_wb_valid !== 1'b0 || io_back_pass_valid !== 1'b0 || io_allow_in !== 1'b1) errors++;
  endtask

  task automatic test_alu_back_to_back();
    @(negedge clock);
    wb_allow_in = 1;
    driveEx(K_ALU, 32'h100, 32'h5, 5'd2, 1'b1);
    @(negedge clock);
    driveEx(K_ALU, 32'h104, 32'h7, 5'd3, 1'b1);
    #1;
    checks++;
    if (io_to_wb_valid !== 1 || io_to_wb_result !== 32'h5 || io_to_wb_destination_register !== 5'd2 ||
        io_to_wb_program_count !== 32'h100 || io_allow_in !== 1) begin
      errors++;
      $display("[TB] FAIL alu_first: got v=%b res=%h rd=%0d pc=%h allow=%b want 1 5 2 100 1",
               io_to_wb_valid, io_to_wb_result, io_to_wb_destination_register,
               io_to_wb_program_count, io_allow_in);
    end
    checks++;
    if (io_back_pass_valid !== 1 || io_back_pass_register !== 5'd2) begin
      errors++;
      $display("[TB] FAIL alu_backpass: got %b/%0d want 1/2", io_back_pass_valid, io_back_pass_register);
    end
    @(negedge clock);
    clearEx();
    #1;
    checks++;
    if (io_to_wb_valid !== 1 || io_to_wb_result !== 32'h7 || io_to_wb_destination_register !== 5'd3 ||
        io_allow_in !== 1) begin
      errors++;
      $display("[TB] FAIL alu_second: got v=%b res=%h rd=%0d allow=%b want 1 7 3 1",
               io_to_wb_valid, io_to_wb_result, io_to_wb_destination_register, io_allow_in);
    end
    @(negedge clock);
    #1;
    checks++;
    if (io_to_wb_valid !== 0 || io_allow_in !== 1) begin
      errors++;
      $display("[TB] FAIL alu_drain: got v=%b allow=%b want 0 1", io_to_wb_valid, io_allow_in);
    end
  endtask

  task automatic test_load_stall();
    @(negedge clock);
    wb_allow_in = 0;
    driveEx(K_LOAD, 32'h200, 32'h8000, 5'd6, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      clearEx();
      data_read_data = (c == 0) ? 32'hDEADBEEF : 32'h0;
      wb_allow_in = (c == 3);
      #1;
      checks++;
      if (io_to_wb_valid !== 1 || io_to_wb_result !== 32'hDEADBEEF || io_allow_in !== (c == 3)) begin
        errors++;
        $display("[TB] FAIL load_stall cyc%0d: got v=%b res=%h allow=%b want 1 deadbeef %b",
                 c, io_to_wb_valid, io_to_wb_result, io_allow_in, (c == 3));
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (io_to_wb_valid !== 0) begin
      errors++;
      $display("[TB] FAIL load_release: got v=%b want 0", io_to_wb_valid);
    end
  endtask

  task automatic test_mult();
    @(negedge clock);
    wb_allow_in = 1;
    driveEx(K_MULT, 32'h300, 32'hABCD, 5'd0, 1'b0);
    @(negedge clock);
    multiply_result = 64'h0000_0001_FFFF_FFFE;
    driveEx(K_MFHI, 32'h304, 32'h0, 5'd4, 1'b1);
    @(posedge clock);
    modelRetire(K_MULT, 32'hABCD, 64'h0000_0001_FFFF_FFFE, 0, 0);
    @(negedge clock);
    multiply_result = 64'h5555_5555_AAAA_AAAA;
    driveEx(K_MFLO, 32'h308, 32'h0, 5'd5, 1'b1);
    #1;
    checks++;
    if (io_to_wb_valid !== 1 || io_to_wb_result !== 32'h1) begin
      errors++;
      $display("[TB] FAIL mfhi_after_mult: got v=%b res=%h want 1 00000001", io_to_wb_valid, io_to_wb_result);
    end
    @(negedge clock);
    clearEx();
    #1;
    checks++;
    if (io_to_wb_valid !== 1 || io_to_wb_result !== 32'hFFFFFFFE) begin
      errors++;
      $display("[TB] FAIL mflo_after_mult: got v=%b res=%h want 1 fffffffe", io_to_wb_valid, io_to_wb_result);
    end
  endtask

  task automatic test_div();
    @(negedge clock);
    wb_allow_in = 1;
    divide_result_valid = 0;
    driveEx(K_DIV, 32'h400, 32'h0, 5'd0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      clearEx();
      #1;
      checks++;
      if (io_to_wb_valid !== 0 || io_allow_in !== 0) begin
        errors++;
        $display("[TB] FAIL div_stall cyc%0d: got v=%b allow=%b want 0 0", c, io_to_wb_valid, io_allow_in);
      end
    end
    @(negedge clock);
    divide_result_valid = 1; divide_result = 32'd7; divide_remain = 32'd3;
    #1;
    checks++;
    if (io_to_wb_valid !== 1 || io_allow_in !== 1) begin
      errors++;
      $display("[TB] FAIL div_done: got v=%b allow=%b want 1 1", io_to_wb_valid, io_allow_in);
    end
    @(posedge clock);
    modelRetire(K_DIV, 0, 0, 32'd7, 32'd3);
    @(negedge clock);
    divide_result_valid = 0; divide_result = 32'hBAD; divide_remain = 32'hBAD;
    driveEx(K_MFHI, 32'h404, 0, 5'd8, 1'b1);
    @(negedge clock);
    driveEx(K_MFLO, 32'h408, 0, 5'd9, 1'b1);
    #1;
    checks++;
    if (io_to_wb_result !== 32'd3) begin
      errors++;
      $display("[TB] FAIL div_hi: got %h want 00000003", io_to_wb_result);
    end
    @(negedge clock);
    clearEx();
    #1;
    checks++;
    if (io_to_wb_result !== 32'd7) begin
      errors++;
      $display("[TB] FAIL div_lo: got %h want 00000007", io_to_wb_result);
    end
  endtask

  task automatic test_mthi();
    @(negedge clock);
    driveEx(K_MTHI, 32'h500, 32'h1234, 5'd0, 1'b0);
    @(negedge clock);
    driveEx(K_MFHI, 32'h504, 0, 5'd10, 1'b1);
    @(posedge clock);
    modelRetire(K_MTHI, 32'h1234, 0, 0, 0);
    @(negedge clock);
    driveEx(K_MFLO, 32'h508, 0, 5'd11, 1'b1);
    #1;
    checks++;
    if (io_to_wb_result !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL mthi_mfhi: got %h want 00001234", io_to_wb_result);
    end
    @(negedge clock);
    clearEx();
    #1;
    checks++;
    if (io_to_wb_result !== 32'd7) begin
      errors++;
      $display("[TB] FAIL mthi_lo_kept: got %h want 00000007", io_to_wb_result);
    end
  endtask

  task automatic test_reset_mid_divide();
    @(negedge clock);
    clearEx();
    @(negedge clock);
    divide_result_valid = 0;
    driveEx(K_DIV, 32'h600, 0, 5'd12, 1'b1);
    @(negedge clock);
    clearEx();
    #1;
    checks++;
    if (io_back_pass_valid !== 1 || io_to_wb_valid !== 0) begin
      errors++;
      $display("[TB] FAIL div_backpass_stalled: got bp=%b v=%b want 1 0", io_back_pass_valid, io_to_wb_valid);
    end
    #1 reset = 1;
    #1;
    checks++;
    if (io_to_wb_valid !== 0 || io_back_pass_valid !== 0 || io_allow_in !== 1) begin
      errors++;
      $display("[TB] FAIL async_reset: got v=%b bp=%b allow=%b want 0 0 1",
               io_to_wb_valid, io_back_pass_valid, io_allow_in);
    end
    #1 reset = 0;
    mHi = '0; mLo = '0;
    @(negedge clock);
    driveEx(K_MFHI, 32'h604, 0, 5'd1, 1'b1);
    @(negedge clock);
    driveEx(K_MFLO, 32'h608, 0, 5'd1, 1'b1);
    #1;
    checks++;
    if (io_to_wb_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_hi: got %h want 00000000", io_to_wb_result);
    end
    @(negedge clock);
    clearEx();
    #1;
    checks++;
    if (io_to_wb_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_lo: got %h want 00000000", io_to_wb_result);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    int          kind;
    int          divLat;
    int          cyc;
    bit          fired;
    bit          expValid;
    logic [31:0] alu, ld, q, r, pc, expRes;
    logic [63:0] mul;
    logic [4:0]  dest;
    logic        rw;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 7);
      alu = $urandom; ld = $urandom; q = $urandom; r = $urandom; pc = $urandom;
      mul = {$urandom, $urandom};
      dest = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      divLat = $urandom_range(0, 5);
      fired = 0;
      cyc = 0;
      @(negedge clock);
      driveEx(kind, pc, alu, dest, rw);
      wb_allow_in = 1'($urandom_range(0, 1));
      divide_result_valid = 1'($urandom_range(0, 1));
      expRes = modelResult(kind, alu, ld);
      #1;
      checks++;
      if (io_allow_in !== 1) begin
        errors++;
        $display("[TB] FAIL rand%0d_empty_allow: got %b want 1", n, io_allow_in);
      end
      while (!fired && cyc < 40) begin
        @(negedge clock);
        clearEx();
        data_read_data = (cyc == 0) ? ld : $urandom;
        multiply_result = (cyc == 0) ? mul : {$urandom, $urandom};
        wb_allow_in = (cyc >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        expValid = (kind != K_DIV) || (cyc >= divLat);
        if (kind == K_DIV) begin
          divide_result_valid = expValid;
          divide_result = expValid ? q : $urandom;
          divide_remain = expValid ? r : $urandom;
        end else begin
          divide_result_valid = 1'($urandom_range(0, 1));
          divide_result = $urandom;
          divide_remain = $urandom;
        end
        #1;
        checks++;
        if (io_to_wb_valid !== expValid || io_back_pass_valid !== rw ||
            io_allow_in !== (expValid && wb_allow_in)) begin
          errors++;
          $display("[TB] FAIL rand%0d_hs kind%0d cyc%0d: got v=%b bp=%b allow=%b want %b %b %b",
                   n, kind, cyc, io_to_wb_valid, io_back_pass_valid, io_allow_in,
                   expValid, rw, expValid && wb_allow_in);
        end
        if (expValid) begin
          checks++;
          if (io_to_wb_result !== expRes || io_to_wb_destination_register !== dest ||
              io_to_wb_program_count !== pc || io_to_wb_register_write !== rw) begin
            errors++;
            $display("[TB] FAIL rand%0d_data kind%0d cyc%0d: got res=%h rd=%0d pc=%h want %h %0d %h",
                     n, kind, cyc, io_to_wb_result, io_to_wb_destination_register,
                     io_to_wb_program_count, expRes, dest, pc);
          end
          if (wb_allow_in) begin
            modelRetire(kind, alu, mul, q, r);
            fired = 1;
          end
        end
        cyc++;
        @(posedge clock);
      end
      if (!fired) begin
        errors++;
        $display("[TB] FAIL rand%0d_timeout: got no fire want fire within 40 cycles", n);
      end
    end
    @(negedge clock);
    divide_result_valid = 0;
  endtask

  initial begin
    reset = 1;
    wb_allow_in = 1;
    multiply_result = '0;
    divide_result_valid = 0;
    divide_result = '0;
    divide_remain = '0;
    data_read_data = '0;
    clearEx();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    test_reset();
    test_alu_back_to_back();
    test_load_stall();
    test_mult();
    test_div();
    test_mthi();
    test_reset_mid_divide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
